md_unit: RTL and testbench

- Multiply/divide unit for the 5-stage MIPS pipeline. Sits in the Execute stage beside the ALU and owns the HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations and executes MTHI/MTLO in a single cycle.
- Drives `busy` into the hazard unit. The hazard unit uses `start | busy` to stall any D-stage MULT/DIV/MFHI/MFLO/MTHI/MTLO instruction and to freeze PC and IF/ID.

---
 rtl/md_unit_pkg.sv | 27 ++
 rtl/md_unit_if.sv | 21 ++
 rtl/md_unit_calc.sv | 63 ++++++
 rtl/md_unit.sv | 111 +++++++++++
 tb/tb_md_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that feeds it.
// Op encoding, default latencies and the unit's FSM state type.
package md_defs;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   function automatic int md_max(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Execute-stage bus between the pipeline (master) and the multiply/divide unit (slave).
// Carries the op request with its forwarded operands, and returns busy plus HI/LO.
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, md_op, a, b,
      input  busy, hi, lo
   );

   modport slave (
      input  start, md_op, a, b,
      output busy, hi, lo
   );
endinterface

// File: rtl/md_unit_calc.sv
// Combinational arithmetic core: 64-bit products and 32-bit quotient/remainder.
// Division is done on magnitudes and the signs are restored afterwards.
module md_calc
   import md_defs::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_by_zero
);

   logic        is_signed;
   logic        is_div;
   logic        a_neg;
   logic        b_neg;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] div_b;
   logic [31:0] quo_mag;
   logic [31:0] rem_mag;

   always_comb begin
      is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
      is_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
      a_neg     = is_signed & a[31];
      b_neg     = is_signed & b[31];

      // The low 64 bits of a 64x64 product of extended operands are the exact result.
      a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
      b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
      prod  = a_ext * b_ext;

      // 0x80000000 has no positive twin but its magnitude is still correct unsigned.
      a_mag   = a_neg ? (32'd0 - a) : a;
      b_mag   = b_neg ? (32'd0 - b) : b;
      div_b   = (b_mag == 32'd0) ? 32'd1 : b_mag;
      quo_mag = a_mag / div_b;
      rem_mag = a_mag % div_b;

      div_by_zero = is_div && (b == 32'd0);

      res_hi = 32'd0;
      res_lo = 32'd0;
      case (md_op)
         MD_MULT, MD_MULTU: begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
         end
         MD_DIV, MD_DIVU: begin
            res_lo = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
            res_hi = a_neg ? (32'd0 - rem_mag) : rem_mag;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. MULT/DIV results are computed at
// the start edge, held as pending, and committed after a fixed busy period.
module md_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic       clk,
   input  logic       reset,
   md_unit_if.slave   bus
);

   localparam int CNT_MAX = md_max(MULT_CYCLES, DIV_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               pend_wr_q, pend_wr_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;

   logic [31:0]        calc_hi;
   logic [31:0]        calc_lo;
   logic               calc_dbz;

   md_calc u_calc (
      .md_op       (bus.md_op),
      .a           (bus.a),
      .b           (bus.b),
      .res_hi      (calc_hi),
      .res_lo      (calc_lo),
      .div_by_zero (calc_dbz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               case (bus.md_op)
                  MD_MULT, MD_MULTU: begin
                     pend_hi_d = calc_hi;
                     pend_lo_d = calc_lo;
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = ST_BUSY;
                  end
                  MD_DIV, MD_DIVU: begin
                     // Divide by zero still occupies the unit but leaves HI/LO alone.
                     pend_hi_d = calc_hi;
                     pend_lo_d = calc_lo;
                     pend_wr_d = ~calc_dbz;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = ST_BUSY;
                  end
                  MD_MTHI: hi_d = bus.a;
                  MD_MTLO: lo_d = bus.a;
                  default: begin
                  end
               endcase
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy = (state_q == ST_BUSY);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a timestamp-based reference model checked every
// cycle, plus directed operations with hand-computed HI/LO and busy-length results.
module tb_md_unit;
   import md_defs::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails  = 0;

   md_unit_if bus ();

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // Returns {write_enable, hi, lo} straight from the arithmetic definitions.
   function automatic logic [64:0] model_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      longint          ps;
      logic [63:0]     pu;
      int              sx, sy, q, r;
      logic [64:0]     res;
      res = '0;
      case (op)
         MD_MULT: begin
            ps  = longint'($signed(x)) * longint'($signed(y));
            res = {1'b1, 64'(ps)};
         end
         MD_MULTU: begin
            pu  = {32'd0, x} * {32'd0, y};
            res = {1'b1, pu};
         end
         MD_DIV: begin
            if (y != 32'd0) begin
               sx = x;
               sy = y;
               if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                  q = sx;
                  r = 0;
               end else begin
                  q = sx / sy;
                  r = sx % sy;
               end
               res = {1'b1, 32'(r), 32'(q)};
            end
         end
         MD_DIVU: begin
            if (y != 32'd0) res = {1'b1, x % y, x / y};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   // Model: an accepted op at edge index e keeps the unit busy until edge e+N.
   int          cyc     = 0;
   int          m_done  = 0;
   logic        m_valid = 1'b0;
   logic [31:0] m_hi    = '0;
   logic [31:0] m_lo    = '0;
   logic [64:0] m_pend  = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_hi    <= '0;
         m_lo    <= '0;
         m_done  <= 0;
         m_pend  <= '0;
         m_valid <= 1'b1;
      end else begin
         if (cyc + 1 == m_done && m_pend[64]) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
         end
         if (bus.start) begin
            if (cyc < m_done) begin
               $display("note: start seen while busy at edge %0d, ignored", cyc + 1);
            end else begin
               case (bus.md_op)
                  MD_MULT, MD_MULTU: begin
                     m_done <= cyc + 1 + MULT_N;
                     m_pend <= model_result(bus.md_op, bus.a, bus.b);
                  end
                  MD_DIV, MD_DIVU: begin
                     m_done <= cyc + 1 + DIV_N;
                     m_pend <= model_result(bus.md_op, bus.a, bus.b);
                  end
                  MD_MTHI: m_hi <= bus.a;
                  MD_MTLO: m_lo <= bus.a;
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_busy", {31'd0, bus.busy}, {31'd0, (cyc < m_done)});
         check("model_hi", bus.hi, m_hi);
         check("model_lo", bus.lo, m_lo);
      end
   end

   // Called 1 time unit after an edge; returns the number of cycles busy was seen high.
   task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int inj_at, input int rst_at, output int n);
      bus.start = 1'b1;
      bus.md_op = op;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         if (n == rst_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            break;
         end
         if (n == inj_at) begin
            bus.start = 1'b1;
            bus.md_op = MD_MTHI;
            bus.a     = 32'h0000_DEAD;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.md_op = MD_NONE;
      end
   endtask

   task automatic single(input logic [2:0] op, input logic [31:0] av);
      bus.start = 1'b1;
      bus.md_op = op;
      bus.a     = av;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      bus.a     = '0;
      bus.b     = '0;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_hi", bus.hi, 32'd0);
      check("reset_lo", bus.lo, 32'd0);

      run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, n);
      $display("MULT  -2*3       : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("mult_cycles", n, 32'd5);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFFA);

      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n);
      $display("MULTU max*max    : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("multu_cycles", n, 32'd5);
      check("multu_hi", bus.hi, 32'hFFFF_FFFE);
      check("multu_lo", bus.lo, 32'h0000_0001);

      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, n);
      $display("DIV   -7/2       : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("div_cycles", n, 32'd10);
      check("div_hi", bus.hi, 32'hFFFF_FFFF);
      check("div_lo", bus.lo, 32'hFFFF_FFFD);

      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
      $display("DIV   min/-1     : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("divovf_hi", bus.hi, 32'h0000_0000);
      check("divovf_lo", bus.lo, 32'h8000_0000);

      single(MD_MTHI, 32'h0000_0011);
      single(MD_MTLO, 32'h0000_0022);
      run_op(MD_DIVU, 32'd100, 32'd0, 0, 0, n);
      $display("DIVU  100/0      : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("divz_cycles", n, 32'd10);
      check("divz_hi", bus.hi, 32'h0000_0011);
      check("divz_lo", bus.lo, 32'h0000_0022);

      bus.start = 1'b1;
      bus.md_op = MD_MTHI;
      bus.a     = 32'h1234_5678;
      @(posedge clk); #1;
      check("mthi_busy", {31'd0, bus.busy}, 32'd0);
      check("mthi_hi", bus.hi, 32'h1234_5678);
      bus.md_op = MD_MTLO;
      bus.a     = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      $display("MTHI/MTLO        : busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
      check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
      check("mtlo_hi", bus.hi, 32'h1234_5678);
      check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);

      run_op(MD_MULT, 32'd7, 32'd6, 2, 0, n);
      $display("MULT  7*6 + MTHI : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("ign_cycles", n, 32'd5);
      check("ign_hi", bus.hi, 32'h0000_0000);
      check("ign_lo", bus.lo, 32'h0000_002A);

      run_op(MD_DIVU, 32'd100, 32'd7, 0, 0, n);
      $display("DIVU  100/7      : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("divu_hi", bus.hi, 32'h0000_0002);
      check("divu_lo", bus.lo, 32'h0000_000E);

      run_op(MD_DIV, 32'd100, 32'd3, 0, 4, n);
      $display("DIV   + reset    : busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mid_hi", bus.hi, 32'd0);
      check("rst_mid_lo", bus.lo, 32'd0);

      run_op(MD_MULT, 32'h0001_0000, 32'h0001_0000, 0, 0, n);
      $display("MULT  2^16*2^16  : cycles=%0d hi=%08h lo=%08h", n, bus.hi, bus.lo);
      check("post_rst_cycles", n, 32'd5);
      check("post_rst_hi", bus.hi, 32'h0000_0001);
      check("post_rst_lo", bus.lo, 32'h0000_0000);

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
      $fatal(1, "timeout");
   end

endmodule
